// File: rtl/decode_stage_ctrl.sv
// decode_stage_ctrl: RV32I/RV32M decode stage that owns the ID/EX control bundle.
// Decodes the IF/ID instruction, flags illegal encodings, interlocks load-use
// hazards, honours flush and multi-cycle EX hold, and counts hazard stall cycles.
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_instr, i_valid        IF/ID instruction and its valid flag
//   i_flush, i_ex_busy      redirect kill, multi-cycle EX hold
//   o_stall_id              combinational hold request for PC and IF/ID
//   o_valid .. o_funct3     registered ID/EX control bundle
//   o_stall_cnt             saturating count of load-use stall cycles
module decode_stage_ctrl #(
    parameter bit          ENABLE_M      = 1'b1,
    parameter bit          HAZARD_DETECT = 1'b1,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [31:0]      i_instr,
    input  logic             i_valid,
    input  logic             i_flush,
    input  logic             i_ex_busy,
    output logic             o_stall_id,
    output logic             o_valid,
    output logic             o_rd_wren,
    output logic             o_mem_wren,
    output logic             o_mem_ren,
    output logic [1:0]       o_wb_sel,
    output logic             o_opa_sel,
    output logic             o_opb_sel,
    output logic [4:0]       o_alu_op,
    output logic             o_br_un,
    output logic             o_is_ctrl,
    output logic             o_illegal,
    output logic [4:0]       o_rd_addr,
    output logic [4:0]       o_rs1_addr,
    output logic [4:0]       o_rs2_addr,
    output logic [2:0]       o_funct3,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_LUI   = 5'd10;
    localparam logic [4:0] ALU_AUIPC = 5'd11;

    typedef struct packed {
        logic       valid;
        logic       rd_wren;
        logic       mem_wren;
        logic       mem_ren;
        logic [1:0] wb_sel;
        logic       opa_sel;
        logic       opb_sel;
        logic [4:0] alu_op;
        logic       br_un;
        logic       is_ctrl;
        logic       illegal;
        logic [4:0] rd_addr;
        logic [4:0] rs1_addr;
        logic [4:0] rs2_addr;
        logic [2:0] funct3;
    } idex_t;

    // Empty bundle; br_un idles high (signed compare)
    function automatic idex_t bubble();
        idex_t b;
        b       = '0;
        b.br_un = 1'b1;
        return b;
    endfunction

    // Base ALU code from funct3; alt selects SUB/SRA
    function automatic logic [4:0] alu_base(input logic [2:0] f3, input logic alt);
        logic [4:0] op;
        case (f3)
            3'b000:  op = alt ? 5'd1 : 5'd0;
            3'b001:  op = 5'd2;
            3'b010:  op = 5'd3;
            3'b011:  op = 5'd4;
            3'b100:  op = 5'd5;
            3'b101:  op = alt ? 5'd7 : 5'd6;
            3'b110:  op = 5'd8;
            default: op = 5'd9;
        endcase
        return op;
    endfunction

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    idex_t      dec;
    idex_t      q;
    logic       ill;
    logic       use_rs1;
    logic       use_rs2;
    logic       hazard;
    logic [CNT_W-1:0] cnt;

    assign opcode = i_instr[6:0];
    assign f3     = i_instr[14:12];
    assign f7     = i_instr[31:25];

    // Instruction decode into a candidate ID/EX bundle
    always_comb begin
        dec          = bubble();
        ill          = 1'b0;
        dec.valid    = 1'b1;
        dec.rd_addr  = i_instr[11:7];
        dec.rs1_addr = i_instr[19:15];
        dec.rs2_addr = i_instr[24:20];
        dec.funct3   = f3;
        case (opcode)
            OPC_LUI: begin
                dec.rd_wren = 1'b1;
                dec.opb_sel = 1'b1;
                dec.alu_op  = ALU_LUI;
            end
            OPC_AUIPC: begin
                dec.rd_wren = 1'b1;
                dec.opa_sel = 1'b1;
                dec.opb_sel = 1'b1;
                dec.alu_op  = ALU_AUIPC;
            end
            OPC_JAL: begin
                dec.rd_wren = 1'b1;
                dec.wb_sel  = 2'b10;
                dec.opa_sel = 1'b1;
                dec.opb_sel = 1'b1;
                dec.is_ctrl = 1'b1;
            end
            OPC_JALR: begin
                dec.rd_wren = 1'b1;
                dec.wb_sel  = 2'b10;
                dec.opb_sel = 1'b1;
                dec.is_ctrl = 1'b1;
                ill         = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                // ALU forms the target; comparator runs on rs1/rs2 separately
                dec.opa_sel = 1'b1;
                dec.opb_sel = 1'b1;
                dec.is_ctrl = 1'b1;
                dec.br_un   = ~(f3[2] & f3[1]);
                ill         = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_LOAD: begin
                dec.rd_wren = 1'b1;
                dec.mem_ren = 1'b1;
                dec.wb_sel  = 2'b01;
                dec.opb_sel = 1'b1;
                ill         = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OPC_STORE: begin
                dec.mem_wren = 1'b1;
                dec.opb_sel  = 1'b1;
                ill          = (f3 >= 3'b011);
            end
            OPC_OPIMM: begin
                dec.rd_wren = 1'b1;
                dec.opb_sel = 1'b1;
                dec.alu_op  = alu_base(f3, (f3 == 3'b101) && f7[5]);
                if (f3 == 3'b001)
                    ill = (f7 != 7'b0000000);
                else if (f3 == 3'b101)
                    ill = (f7 != 7'b0000000) && (f7 != 7'b0100000);
            end
            OPC_OP: begin
                dec.rd_wren = 1'b1;
                case (f7)
                    7'b0000000: dec.alu_op = alu_base(f3, 1'b0);
                    7'b0100000: begin
                        dec.alu_op = alu_base(f3, 1'b1);
                        ill        = (f3 != 3'b000) && (f3 != 3'b101);
                    end
                    7'b0000001: begin
                        dec.alu_op = {2'b10, f3};
                        ill        = !ENABLE_M;
                    end
                    default: ill = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase
        // Illegal encodings travel as a valid bubble so WB can trap
        if (ill) begin
            dec         = bubble();
            dec.valid   = 1'b1;
            dec.illegal = 1'b1;
        end
    end

    // Source-register usage by opcode, independent of legality
    assign use_rs1 = (opcode != OPC_LUI) && (opcode != OPC_AUIPC) && (opcode != OPC_JAL);
    assign use_rs2 = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);

    assign hazard = HAZARD_DETECT && i_valid && q.valid && q.mem_ren && (q.rd_addr != 5'd0)
                    && ((use_rs1 && (i_instr[19:15] == q.rd_addr))
                     || (use_rs2 && (i_instr[24:20] == q.rd_addr)));

    assign o_stall_id = !i_reset && !i_flush && (i_ex_busy || hazard);

    // ID/EX register and stall counter, priority reset > flush > busy > hazard > idle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            q   <= bubble();
            cnt <= '0;
        end else if (i_flush) begin
            q <= bubble();
        end else if (i_ex_busy) begin
            q <= q;
        end else if (hazard) begin
            q <= bubble();
            if (cnt != {CNT_W{1'b1}})
                cnt <= cnt + CNT_W'(1);
        end else if (!i_valid) begin
            q <= bubble();
        end else begin
            q <= dec;
        end
    end

    assign o_valid     = q.valid;
    assign o_rd_wren   = q.rd_wren;
    assign o_mem_wren  = q.mem_wren;
    assign o_mem_ren   = q.mem_ren;
    assign o_wb_sel    = q.wb_sel;
    assign o_opa_sel   = q.opa_sel;
    assign o_opb_sel   = q.opb_sel;
    assign o_alu_op    = q.alu_op;
    assign o_br_un     = q.br_un;
    assign o_is_ctrl   = q.is_ctrl;
    assign o_illegal   = q.illegal;
    assign o_rd_addr   = q.rd_addr;
    assign o_rs1_addr  = q.rs1_addr;
    assign o_rs2_addr  = q.rs2_addr;
    assign o_funct3    = q.funct3;
    assign o_stall_cnt = cnt;

endmodule

// File: tb/tb_decode_stage_ctrl.sv
// tb_decode_stage_ctrl: directed checks of decode_stage_ctrl, with ENABLE_M=1
// (dut) and ENABLE_M=0 (dut_nom) fed the same IF/ID stream.
module tb_decode_stage_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic        valid;
    logic        flush;
    logic        ex_busy;

    logic        stall_id, o_valid, rd_wren, mem_wren, mem_ren;
    logic [1:0]  wb_sel;
    logic        opa_sel, opb_sel, br_un, is_ctrl, illegal;
    logic [4:0]  alu_op, rd_addr, rs1_addr, rs2_addr;
    logic [2:0]  funct3;
    logic [31:0] stall_cnt;

    logic        n_stall_id, n_valid, n_rd_wren, n_mem_wren, n_mem_ren;
    logic [1:0]  n_wb_sel;
    logic        n_opa_sel, n_opb_sel, n_br_un, n_is_ctrl, n_illegal;
    logic [4:0]  n_alu_op, n_rd_addr, n_rs1_addr, n_rs2_addr;
    logic [2:0]  n_funct3;
    logic [31:0] n_stall_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    decode_stage_ctrl #(.ENABLE_M(1'b1), .HAZARD_DETECT(1'b1), .CNT_W(32)) dut (
        .i_clk(clk), .i_reset(reset), .i_instr(instr), .i_valid(valid),
        .i_flush(flush), .i_ex_busy(ex_busy), .o_stall_id(stall_id),
        .o_valid(o_valid), .o_rd_wren(rd_wren), .o_mem_wren(mem_wren),
        .o_mem_ren(mem_ren), .o_wb_sel(wb_sel), .o_opa_sel(opa_sel),
        .o_opb_sel(opb_sel), .o_alu_op(alu_op), .o_br_un(br_un),
        .o_is_ctrl(is_ctrl), .o_illegal(illegal), .o_rd_addr(rd_addr),
        .o_rs1_addr(rs1_addr), .o_rs2_addr(rs2_addr), .o_funct3(funct3),
        .o_stall_cnt(stall_cnt)
    );

    decode_stage_ctrl #(.ENABLE_M(1'b0), .HAZARD_DETECT(1'b1), .CNT_W(32)) dut_nom (
        .i_clk(clk), .i_reset(reset), .i_instr(instr), .i_valid(valid),
        .i_flush(flush), .i_ex_busy(ex_busy), .o_stall_id(n_stall_id),
        .o_valid(n_valid), .o_rd_wren(n_rd_wren), .o_mem_wren(n_mem_wren),
        .o_mem_ren(n_mem_ren), .o_wb_sel(n_wb_sel), .o_opa_sel(n_opa_sel),
        .o_opb_sel(n_opb_sel), .o_alu_op(n_alu_op), .o_br_un(n_br_un),
        .o_is_ctrl(n_is_ctrl), .o_illegal(n_illegal), .o_rd_addr(n_rd_addr),
        .o_rs1_addr(n_rs1_addr), .o_rs2_addr(n_rs2_addr), .o_funct3(n_funct3),
        .o_stall_cnt(n_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    localparam logic [6:0] OP  = 7'b0110011;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JR  = 7'b1100111;

    logic [31:0] ill_vec [4];

    initial begin
        reset   = 1'b1;
        valid   = 1'b1;
        flush   = 1'b0;
        ex_busy = 1'b0;
        instr   = r_type(7'b0, 5'd2, 5'd1, 3'b000, 5'd3, OP);   // ADD x3,x1,x2

        // Reset while feeding ADD
        step();
        step();
        check("rst_valid",    32'(o_valid),   32'd0);
        check("rst_rd_wren",  32'(rd_wren),   32'd0);
        check("rst_br_un",    32'(br_un),     32'd1);
        check("rst_rd_addr",  32'(rd_addr),   32'd0);
        check("rst_cnt",      stall_cnt,      32'd0);
        check("rst_stall_id", 32'(stall_id),  32'd0);

        // First instruction after release
        reset = 1'b0;
        step();
        check("add_valid",   32'(o_valid), 32'd1);
        check("add_alu",     32'(alu_op),  32'd0);
        check("add_rd_wren", 32'(rd_wren), 32'd1);
        check("add_rd_addr", 32'(rd_addr), 32'd3);
        check("add_wb_sel",  32'(wb_sel),  32'd0);
        check("add_illegal", 32'(illegal), 32'd0);

        // Load-use: LW x5,0(x1) then ADD x6,x5,x2
        instr = i_type(12'd0, 5'd1, 3'b010, 5'd5, LD);
        step();
        check("lw_mem_ren", 32'(mem_ren), 32'd1);
        check("lw_wb_sel",  32'(wb_sel),  32'd1);
        instr = r_type(7'b0, 5'd2, 5'd5, 3'b000, 5'd6, OP);
        #1;
        check("lu_stall_id", 32'(stall_id), 32'd1);
        step();
        check("lu_bubble_valid", 32'(o_valid),  32'd0);
        check("lu_cnt",          stall_cnt,     32'd1);
        check("lu_stall_clear",  32'(stall_id), 32'd0);
        step();
        check("lu_issue_valid", 32'(o_valid), 32'd1);
        check("lu_issue_rd",    32'(rd_addr), 32'd6);
        check("lu_issue_cnt",   stall_cnt,    32'd1);

        // Load into x0 never interlocks
        instr = i_type(12'd0, 5'd1, 3'b010, 5'd0, LD);
        step();
        instr = r_type(7'b0, 5'd2, 5'd0, 3'b000, 5'd6, OP);
        #1;
        check("x0_stall_id", 32'(stall_id), 32'd0);
        step();
        check("x0_valid", 32'(o_valid), 32'd1);
        check("x0_rd",    32'(rd_addr), 32'd6);
        check("x0_cnt",   stall_cnt,    32'd1);

        // DIVU x7,x8,x9 on both M configurations
        instr = r_type(7'b0000001, 5'd9, 5'd8, 3'b101, 5'd7, OP);
        step();
        check("divu_alu",      32'(alu_op),    32'd21);
        check("divu_illegal",  32'(illegal),   32'd0);
        check("divu_rd_wren",  32'(rd_wren),   32'd1);
        check("nom_illegal",   32'(n_illegal), 32'd1);
        check("nom_valid",     32'(n_valid),   32'd1);
        check("nom_rd_wren",   32'(n_rd_wren), 32'd0);
        check("nom_alu",       32'(n_alu_op),  32'd0);

        // Flush beats a simultaneous hazard and busy
        instr = i_type(12'd0, 5'd1, 3'b010, 5'd5, LD);
        step();
        instr   = r_type(7'b0, 5'd2, 5'd5, 3'b000, 5'd6, OP);
        flush   = 1'b1;
        ex_busy = 1'b1;
        #1;
        check("fl_stall_id", 32'(stall_id), 32'd0);
        step();
        check("fl_valid", 32'(o_valid), 32'd0);
        check("fl_cnt",   stall_cnt,    32'd1);
        flush   = 1'b0;
        ex_busy = 1'b0;

        // BLTU x1,x2 then hold for 3 busy cycles while SUB waits upstream
        instr = r_type(7'b0, 5'd2, 5'd1, 3'b110, 5'd0, BR);
        step();
        check("bltu_br_un",   32'(br_un),   32'd0);
        check("bltu_is_ctrl", 32'(is_ctrl), 32'd1);
        check("bltu_valid",   32'(o_valid), 32'd1);
        instr   = r_type(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd4, OP);  // SUB x4,x1,x2
        ex_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("busy_stall_id", 32'(stall_id), 32'd1);
            step();
            check("busy_br_un",   32'(br_un),    32'd0);
            check("busy_is_ctrl", 32'(is_ctrl),  32'd1);
            check("busy_funct3",  32'(funct3),   32'd6);
            check("busy_cnt",     stall_cnt,     32'd1);
        end
        ex_busy = 1'b0;
        step();
        check("sub_alu",     32'(alu_op),  32'd1);
        check("sub_is_ctrl", 32'(is_ctrl), 32'd0);
        check("sub_rd",      32'(rd_addr), 32'd4);

        // Illegal sweep
        ill_vec[0] = i_type(12'd0, 5'd1, 3'b111, 5'd5, LD);
        ill_vec[1] = {7'b0, 5'd2, 5'd1, 3'b011, 5'd0, ST};
        ill_vec[2] = i_type(12'd0, 5'd1, 3'b001, 5'd5, JR);
        ill_vec[3] = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            instr = ill_vec[i];
            step();
            check("ill_flag",   32'(illegal), 32'd1);
            check("ill_valid",  32'(o_valid), 32'd1);
            check("ill_enables", 32'({rd_wren, mem_wren, mem_ren}), 32'd0);
        end

        // Invalid IF/ID loads a bubble
        valid = 1'b0;
        step();
        check("inv_valid", 32'(o_valid), 32'd0);
        valid = 1'b1;

        // Reset mid-operation with a pending hazard
        instr = i_type(12'd0, 5'd1, 3'b010, 5'd5, LD);
        step();
        instr = r_type(7'b0, 5'd2, 5'd5, 3'b000, 5'd6, OP);
        reset = 1'b1;
        #1;
        check("rst2_stall_id", 32'(stall_id), 32'd0);
        step();
        check("rst2_valid", 32'(o_valid), 32'd0);
        check("rst2_cnt",   stall_cnt,    32'd0);
        check("rst2_ren",   32'(mem_ren), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
